// File: rtl/hdmi_pkg.sv
// Shared types and timing presets for the HDMI video timing controller.
// Presets feed the parameter defaults of hdmi_timing.
package hdmi_pkg;

  localparam logic NO  = 1'b0;
  localparam logic YES = 1'b1;

  typedef struct packed {
    logic [15:0] h_active;
    logic [15:0] h_front;
    logic [15:0] h_sync;
    logic [15:0] h_back;
    logic [15:0] v_active;
    logic [15:0] v_front;
    logic [15:0] v_sync;
    logic [15:0] v_back;
    logic        h_pol;
    logic        v_pol;
  } hdmi_timing_t;

  localparam hdmi_timing_t TIMING_640X480_60 = '{
    h_active: 16'd640,  h_front: 16'd16,  h_sync: 16'd96, h_back: 16'd48,
    v_active: 16'd480,  v_front: 16'd10,  v_sync: 16'd2,  v_back: 16'd33,
    h_pol: NO, v_pol: NO
  };

  localparam hdmi_timing_t TIMING_1280X720_60 = '{
    h_active: 16'd1280, h_front: 16'd110, h_sync: 16'd40, h_back: 16'd220,
    v_active: 16'd720,  v_front: 16'd5,   v_sync: 16'd5,  v_back: 16'd20,
    h_pol: YES, v_pol: YES
  };

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } hdmi_state_t;

endpackage

// File: rtl/hdmi_delay.sv
// Fixed-depth shift register with async active-low reset and a per-bit
// reset value, so sync lines can rest at their deasserted level.
module hdmi_delay #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [DEPTH-1:0][WIDTH-1:0] r_pipe;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int s = 0; s < DEPTH; s++) r_pipe[s] <= RST_VAL;
    end else begin
      r_pipe[0] <= i_d;
      for (int s = 1; s < DEPTH; s++) r_pipe[s] <= r_pipe[s-1];
    end
  end

  assign o_q = r_pipe[DEPTH-1];

endmodule

// File: rtl/hdmi_timing.sv
// Video timing controller: early hc/vc counters drive a fetch strobe, and the
// encoder-facing active/h_sync/v_sync lag it by LEAD clocks.
module hdmi_timing
  import hdmi_pkg::*;
#(
  parameter int H_ACTIVE   = int'(TIMING_640X480_60.h_active),
  parameter int H_FRONT    = int'(TIMING_640X480_60.h_front),
  parameter int H_SYNC     = int'(TIMING_640X480_60.h_sync),
  parameter int H_BACK     = int'(TIMING_640X480_60.h_back),
  parameter int V_ACTIVE   = int'(TIMING_640X480_60.v_active),
  parameter int V_FRONT    = int'(TIMING_640X480_60.v_front),
  parameter int V_SYNC     = int'(TIMING_640X480_60.v_sync),
  parameter int V_BACK     = int'(TIMING_640X480_60.v_back),
  parameter bit H_SYNC_POL = TIMING_640X480_60.h_pol,
  parameter bit V_SYNC_POL = TIMING_640X480_60.v_pol,
  parameter int LEAD       = 2
) (
  input  logic        clk,
  input  logic        reset_low,
  input  logic        enable,
  output logic        running,
  output logic        frame_start,
  output logic        fetch,
  output logic [11:0] fetch_x,
  output logic [10:0] fetch_y,
  output logic        active,
  output logic        h_sync,
  output logic        v_sync
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;
  localparam int HS_BEG  = H_ACTIVE + H_FRONT;
  localparam int HS_END  = HS_BEG + H_SYNC;
  localparam int VS_BEG  = V_ACTIVE + V_FRONT;
  localparam int VS_END  = VS_BEG + V_SYNC;
  localparam logic [2:0] DLY_RST = {1'b0, !H_SYNC_POL, !V_SYNC_POL};

  if (LEAD < 1 || LEAD > 8) begin : g_bad_lead
    $error("hdmi_timing: LEAD must be within 1..8");
  end
  if (LEAD >= H_FRONT + H_SYNC + H_BACK) begin : g_bad_blank
    $error("hdmi_timing: LEAD must be shorter than horizontal blanking");
  end
  if (H_ACTIVE > 4096) begin : g_bad_hact
    $error("hdmi_timing: H_ACTIVE exceeds 4096");
  end
  if (V_ACTIVE > 2048) begin : g_bad_vact
    $error("hdmi_timing: V_ACTIVE exceeds 2048");
  end

  hdmi_state_t   r_state, w_state_nx;
  logic [HW-1:0] r_hc, w_hc_nx;
  logic [VW-1:0] r_vc, w_vc_nx;

  logic        r_running, r_frame_start, r_fetch, r_e_hs, r_e_vs;
  logic [11:0] r_fetch_x;
  logic [10:0] r_fetch_y;

  logic w_run_nx, w_e_act, w_in_hs, w_in_vs, w_fs_nx;
  logic [2:0] w_dly;

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      r_state <= ST_IDLE;
      r_hc    <= '0;
      r_vc    <= '0;
    end else begin
      r_state <= w_state_nx;
      r_hc    <= w_hc_nx;
      r_vc    <= w_vc_nx;
    end
  end

  // Enable only matters in IDLE and on the last cycle of a frame.
  always_comb begin
    w_state_nx = r_state;
    w_hc_nx    = r_hc;
    w_vc_nx    = r_vc;
    unique case (r_state)
      ST_IDLE: begin
        w_hc_nx = '0;
        w_vc_nx = '0;
        if (enable) w_state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (int'(r_hc) == H_TOTAL - 1) begin
          w_hc_nx = '0;
          if (int'(r_vc) == V_TOTAL - 1) begin
            w_vc_nx = '0;
            if (!enable) w_state_nx = ST_IDLE;
          end else begin
            w_vc_nx = r_vc + 1'b1;
          end
        end else begin
          w_hc_nx = r_hc + 1'b1;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  // Outputs are decoded from next-state counters and registered, so the
  // cycle showing hc/vc also shows its own strobes.
  assign w_run_nx = (w_state_nx == ST_RUN);
  assign w_e_act  = w_run_nx && (int'(w_hc_nx) < H_ACTIVE) && (int'(w_vc_nx) < V_ACTIVE);
  assign w_in_hs  = w_run_nx && (int'(w_hc_nx) >= HS_BEG) && (int'(w_hc_nx) < HS_END);
  assign w_in_vs  = w_run_nx && (int'(w_vc_nx) >= VS_BEG) && (int'(w_vc_nx) < VS_END);
  assign w_fs_nx  = w_run_nx && (w_hc_nx == '0) && (w_vc_nx == '0);

  always_ff @(posedge clk or negedge reset_low) begin
    if (!reset_low) begin
      r_running     <= 1'b0;
      r_frame_start <= 1'b0;
      r_fetch       <= 1'b0;
      r_fetch_x     <= '0;
      r_fetch_y     <= '0;
      r_e_hs        <= !H_SYNC_POL;
      r_e_vs        <= !V_SYNC_POL;
    end else begin
      r_running     <= w_run_nx;
      r_frame_start <= w_fs_nx;
      r_fetch       <= w_e_act;
      r_fetch_x     <= w_e_act ? 12'(w_hc_nx) : '0;
      r_fetch_y     <= w_e_act ? 11'(w_vc_nx) : '0;
      r_e_hs        <= w_in_hs ? H_SYNC_POL : !H_SYNC_POL;
      r_e_vs        <= w_in_vs ? V_SYNC_POL : !V_SYNC_POL;
    end
  end

  hdmi_delay #(
    .WIDTH   (3),
    .DEPTH   (LEAD),
    .RST_VAL (DLY_RST)
  ) u_delay (
    .i_clk   (clk),
    .i_rst_n (reset_low),
    .i_d     ({r_fetch, r_e_hs, r_e_vs}),
    .o_q     (w_dly)
  );

  assign running     = r_running;
  assign frame_start = r_frame_start;
  assign fetch       = r_fetch;
  assign fetch_x     = r_fetch_x;
  assign fetch_y     = r_fetch_y;
  assign active      = w_dly[2];
  assign h_sync      = w_dly[1];
  assign v_sync      = w_dly[0];

endmodule

// File: tb/tb_hdmi_timing.sv
// Directed bench for hdmi_timing on a 15x8 timing, LEAD 2, active-high syncs.
module tb_hdmi_timing;

  logic        clk = 1'b0;
  logic        reset_low = 1'b0;
  logic        enable = 1'b0;
  logic        running, frame_start, fetch, active, h_sync, v_sync;
  logic [11:0] fetch_x;
  logic [10:0] fetch_y;
  logic [28:0] obs;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int f1 = 0, f2 = 0, acnt = 0, nfr = 0;

  always #5 clk = ~clk;

  hdmi_timing #(
    .H_ACTIVE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
    .V_ACTIVE(4), .V_FRONT(1), .V_SYNC(2), .V_BACK(1),
    .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b1), .LEAD(2)
  ) dut (
    .clk(clk), .reset_low(reset_low), .enable(enable),
    .running(running), .frame_start(frame_start), .fetch(fetch),
    .fetch_x(fetch_x), .fetch_y(fetch_y), .active(active),
    .h_sync(h_sync), .v_sync(v_sync)
  );

  assign obs = {running, frame_start, fetch, fetch_x, fetch_y, active, h_sync, v_sync};

  typedef struct {
    logic        en;
    logic [28:0] exp;
  } vec_t;

  vec_t vecs[20];

  function automatic logic [28:0] mk(bit run, bit fs, bit fe, int x, int y,
                                     bit ac, bit hs, bit vs);
    return {run, fs, fe, 12'(x), 11'(y), ac, hs, vs};
  endfunction

  task automatic step;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, got, want);
    end
  endtask

  task automatic wait_fs(input int budget, output bit found);
    found = 1'b0;
    for (int i = 0; i < budget && !found; i++) begin
      step;
      if (frame_start) found = 1'b1;
    end
    if (!found) chk("fs_timeout", 0, 1);
  endtask

  // One monitored cycle of the randomized run.
  task automatic mon_cycle;
    step;
    chk("lead_align", {31'd0, active}, f2);
    f2 = f1;
    f1 = int'(fetch);
    if (frame_start) begin
      chk("fs_pixel", {8'd0, fetch, fetch_x, fetch_y}, {8'd0, 1'b1, 12'd0, 11'd0});
      if (nfr > 0) chk("frame_active", acnt, 32);
      acnt = 0;
      nfr++;
    end
    if (active) acnt++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, fs1, fs2, fs3, cnt_a, cnt_b, cnt_c, run_h, max_h, run_v, max_v, guard;
    bit found;

    // Idle entries, then the first frame from enable rising at cycle 0.
    for (int i = 0; i < 20; i++) begin
      if (i < 3) begin
        vecs[i].en  = 1'b0;
        vecs[i].exp = mk(0, 0, 0, 0, 0, 0, 0, 0);
      end else begin
        k = i - 2;
        vecs[i].en  = 1'b1;
        vecs[i].exp = mk(1, k == 1,
                         (k <= 8) || (k >= 16),
                         (k <= 8) ? k - 1 : ((k >= 16) ? k - 16 : 0),
                         (k >= 16) ? 1 : 0,
                         (k >= 3) && (k <= 10),
                         (k >= 13) && (k <= 15),
                         0);
      end
    end

    repeat (3) @(negedge clk);
    chk("reset_state", obs, 0);
    #2 reset_low = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step;
      chk("idle_hold", obs, 0);
    end

    fs1 = 0;
    for (int i = 0; i < 20; i++) begin
      enable = vecs[i].en;
      step;
      if (i == 3) fs1 = cyc;
      chk($sformatf("vec%0d", i), obs, vecs[i].exp);
    end

    // Full frame: sync widths and frame period.
    wait_fs(200, found);
    fs2 = cyc;
    chk("fs_period1", fs2 - fs1, 120);
    cnt_a = 0; run_h = 0; max_h = 0; run_v = 0; max_v = 0;
    for (int j = 0; j < 120; j++) begin
      if (j > 0) step;
      if (h_sync) begin cnt_a++; run_h++; end else run_h = 0;
      if (v_sync) run_v++; else run_v = 0;
      if (run_h > max_h) max_h = run_h;
      if (run_v > max_v) max_v = run_v;
    end
    chk("hsync_count", cnt_a, 24);
    chk("hsync_width", max_h, 3);
    chk("vsync_width", max_v, 30);
    wait_fs(10, found);
    fs3 = cyc;
    chk("fs_period2", fs3 - fs2, 120);

    // Enable dropped mid-frame: the frame still completes.
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int j = 0; j < 120; j++) begin
      if (j == 10) enable = 1'b0;
      if (j > 0) step;
      if (fetch) cnt_a++;
      if (running) cnt_b++;
      if (frame_start) cnt_c++;
    end
    chk("stop_fetches", cnt_a, 32);
    chk("stop_running", cnt_b, 120);
    chk("stop_fs", cnt_c, 1);
    step;
    chk("stop_obs", obs, 0);
    cnt_a = 0;
    for (int j = 0; j < 60; j++) begin
      step;
      if (fetch || running || frame_start || active) cnt_a++;
    end
    chk("stopped_quiet", cnt_a, 0);

    // Reset in the middle of an active line.
    enable = 1'b1;
    step;
    chk("restart", obs, mk(1, 1, 1, 0, 0, 0, 0, 0));
    repeat (3) step;
    chk("mid_line", obs, mk(1, 0, 1, 3, 0, 1, 0, 0));
    #2 reset_low = 1'b0;
    #1 chk("async_rst", obs, 0);
    enable = 1'b0;
    step;
    chk("rst_held", obs, 0);
    #2 reset_low = 1'b1;
    step;
    chk("post_rst_idle", obs, 0);
    enable = 1'b1;
    step;
    chk("clean_fs", obs, mk(1, 1, 1, 0, 0, 0, 0, 0));
    repeat (2) step;
    chk("clean_act", obs, mk(1, 0, 1, 2, 0, 1, 0, 0));

    // Randomized enable over 50 frames.
    enable = 1'b0;
    #2 reset_low = 1'b0;
    step;
    #2 reset_low = 1'b1;
    step;
    f1 = 0; f2 = 0; acnt = 0; nfr = 0; guard = 0;
    while (nfr < 50 && guard < 30000) begin
      if ($urandom_range(0, 99) < 2) enable = !enable;
      mon_cycle;
      guard++;
    end
    if (nfr < 50) chk("rand_frames", nfr, 50);
    enable = 1'b0;
    repeat (250) mon_cycle;
    chk("frame_active_last", acnt, 32);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
